row_buf_ctrl: RTL and testbench

Write-side sequencer for the 5-lane row buffer.
- Accepts variable-width beats of 1..5 words from the upstream lane packer.
- Grants as many words as fit in the current row.
- Drives the buffer's `pop_num`/`addr` write controls and pulses `row_fini` when a row of `ROW_LEN` words is complete.
- Holds off further input until the downstream consumer acknowledges the row with `drain_ack`.

---
 rtl/row_buf_ctrl_if.sv | 28 ++
 rtl/row_buf_ctrl.sv | 131 +++++++++++++
 tb/tb_row_buf_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/row_buf_ctrl_if.sv
// Write-side handshake bundle for row_buf_ctrl: upstream beat offer/grant,
// buffer write controls, and row-complete / drain handshake.
interface row_buf_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  in_valid;
    logic [2:0]            in_cnt;
    logic                  in_ready;
    logic [2:0]            in_taken;
    logic [2:0]            pop_num;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  row_fini;
    logic                  row_done;
    logic                  drain_ack;
    logic [15:0]           row_cnt;

    // Environment side: lane packer plus downstream consumer
    modport master (
        output in_valid, in_cnt, drain_ack,
        input  in_ready, in_taken, pop_num, addr, row_fini, row_done, row_cnt
    );

    // Controller side
    modport slave (
        input  in_valid, in_cnt, drain_ack,
        output in_ready, in_taken, pop_num, addr, row_fini, row_done, row_cnt
    );
endinterface

// File: rtl/row_buf_ctrl.sv
// row_buf_ctrl: write-side sequencer for the 5-lane row buffer.
// Grants up to 5 words per beat, clipped to the room left in the row, issues
// registered pop_num/addr one cycle after the grant, pulses row_fini once the
// row is full and then stalls input until drain_ack.
// Optional build macro: ROW_BUF_CTRL_STATS_EN adds a saturating completed-row
// counter on row_cnt; without it row_cnt is tied to zero.
module row_buf_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int ROW_LEN    = 8
) (
    input logic          clk,
    input logic          rst,
    row_buf_ctrl_if.slave bus
);
    localparam int FW    = ADDR_WIDTH + 1;
    // Arithmetic width: must hold both ROW_LEN (<= RAM_DEPTH) and a 0..5 count
    localparam int DW    = $clog2(RAM_DEPTH + 1);
    localparam int CW    = (DW > 3) ? DW : 3;
    localparam logic [CW-1:0] ROW_LEN_C = CW'(ROW_LEN);
    localparam logic [CW-1:0] MAX_BEAT  = CW'(5);

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        CLOSE      = 2'd1,
        WAIT_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [2:0]            pop_num_q, pop_num_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  row_fini_q, row_fini_d;
    logic                  row_done_q, row_done_d;

    logic [CW-1:0] eff_w, room_w, grant_w, new_fill_w;
    logic          accept;

    // Beat sizing: clamp the offer to 5 and to the words left in the row
    always_comb begin
        eff_w      = (bus.in_cnt > 3'd5) ? MAX_BEAT : CW'(bus.in_cnt);
        room_w     = ROW_LEN_C - CW'(fill_q);
        grant_w    = (eff_w < room_w) ? eff_w : room_w;
        new_fill_w = CW'(fill_q) + grant_w;
    end

    // Next-state and handshake outputs; in_ready is masked while reset is held
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        addr_d       = addr_q;
        pop_num_d    = 3'd0;
        row_fini_d   = 1'b0;
        row_done_d   = 1'b0;
        accept       = 1'b0;
        bus.in_ready = 1'b0;
        bus.in_taken = 3'd0;
        case (state_q)
            FILL: begin
                bus.in_ready = ~rst;
                accept       = ~rst & bus.in_valid & (eff_w != '0);
                if (accept) begin
                    bus.in_taken = grant_w[2:0];
                    pop_num_d    = grant_w[2:0];
                    addr_d       = fill_q[ADDR_WIDTH-1:0];
                    fill_d       = new_fill_w[FW-1:0];
                    if (new_fill_w == ROW_LEN_C) state_d = CLOSE;
                end
            end
            // Final write is on the bus this cycle; row_fini follows next cycle
            CLOSE: begin
                row_fini_d = 1'b1;
                state_d    = WAIT_DRAIN;
            end
            WAIT_DRAIN: begin
                if (bus.drain_ack) begin
                    fill_d  = '0;
                    addr_d  = '0;
                    state_d = FILL;
                end else begin
                    row_done_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and registered write controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            fill_q     <= '0;
            pop_num_q  <= 3'd0;
            addr_q     <= '0;
            row_fini_q <= 1'b0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            pop_num_q  <= pop_num_d;
            addr_q     <= addr_d;
            row_fini_q <= row_fini_d;
            row_done_q <= row_done_d;
        end
    end

    assign bus.pop_num  = pop_num_q;
    assign bus.addr     = addr_q;
    assign bus.row_fini = row_fini_q;
    assign bus.row_done = row_done_q;

`ifdef ROW_BUF_CTRL_STATS_EN
    logic [15:0] row_cnt_q, row_cnt_d;

    // Count closed rows, sticking at all-ones
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (row_fini_q && (row_cnt_q != 16'hFFFF)) row_cnt_d = row_cnt_q + 16'd1;
    end

    // Row counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) row_cnt_q <= 16'd0;
        else     row_cnt_q <= row_cnt_d;
    end

    assign bus.row_cnt = row_cnt_q;
`else
    assign bus.row_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_row_buf_ctrl.sv
// Bench for row_buf_ctrl: directed beats with literal checks, plus a
// timeline model (row fill level, close cycle, drain) compared every cycle.
module tb_row_buf_ctrl;
    localparam int AW = 3;
    localparam int RD = 8;
    localparam int RL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    row_buf_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    row_buf_ctrl #(.ADDR_WIDTH(AW), .RAM_DEPTH(RD), .ROW_LEN(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Timeline model: words in row, whether the row is closed, the cycle of
    // the final grant, and the last registered write command.
    int m_fill = 0;
    bit m_busy = 1'b0;
    int m_fin  = -100;
    int m_pop  = 0;
    int m_addr = 0;
    int m_rows = 0;

    always @(negedge clk) begin : cmp
        int e, tk, fini, done, rdy;
        if (rst) begin
            chk("m_rst_ready", bus.in_ready, 0);
            chk("m_rst_taken", bus.in_taken, 0);
            chk("m_rst_pop", bus.pop_num, 0);
            chk("m_rst_addr", bus.addr, 0);
            chk("m_rst_fini", bus.row_fini, 0);
            chk("m_rst_done", bus.row_done, 0);
            chk("m_rst_cnt", bus.row_cnt, 0);
            m_fill = 0; m_busy = 1'b0; m_fin = -100; m_pop = 0; m_addr = 0; m_rows = 0;
        end else begin
            rdy  = m_busy ? 0 : 1;
            e    = (bus.in_cnt > 5) ? 5 : int'(bus.in_cnt);
            tk   = (rdy == 1 && bus.in_valid && e > 0) ? ((e < RL - m_fill) ? e : RL - m_fill) : 0;
            fini = (cyc == m_fin + 2) ? 1 : 0;
            done = (m_busy && cyc >= m_fin + 3) ? 1 : 0;
            chk("m_ready", bus.in_ready, rdy);
            chk("m_taken", bus.in_taken, tk);
            chk("m_pop", bus.pop_num, m_pop);
            chk("m_addr", bus.addr, m_addr);
            chk("m_fini", bus.row_fini, fini);
            chk("m_done", bus.row_done, done);
            chk("m_rowcnt", bus.row_cnt, m_rows);
`ifdef ROW_BUF_CTRL_STATS_EN
            if (fini == 1 && m_rows < 65535) m_rows++;
`endif
            if (m_busy && bus.drain_ack && cyc >= m_fin + 2) begin
                m_busy = 1'b0; m_fill = 0; m_addr = 0;
            end
            m_pop = tk;
            if (tk > 0) begin
                m_addr = m_fill % RD;
                m_fill += tk;
                if (m_fill == RL) begin
                    m_busy = 1'b1;
                    m_fin  = cyc;
                end
            end
        end
    end

    task automatic step(input bit v, input int c, input bit a);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_cnt    = 3'(c);
        bus.drain_ack = a;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_cnt = 3'd0; bus.drain_ack = 1'b0;
        #2 chk("rst_ready", bus.in_ready, 0);
        chk("rst_addr", bus.addr, 0);
        step(0, 0, 0); step(0, 0, 0);
        rst = 1'b0;
        #2 chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_addr", bus.addr, 0);

        // Row 1: 3,3,3 -> grants 3,3,2; drain_ack during CLOSE is ignored
        step(1, 3, 0); #2 chk("r1_take0", bus.in_taken, 3);
        step(1, 3, 0); #2 chk("r1_take1", bus.in_taken, 3);
        chk("r1_pop0", bus.pop_num, 3); chk("r1_addr0", bus.addr, 0);
        step(1, 3, 0); #2 chk("r1_take2", bus.in_taken, 2);
        chk("r1_pop1", bus.pop_num, 3); chk("r1_addr1", bus.addr, 3);
        step(0, 0, 1); #2 chk("r1_pop2", bus.pop_num, 2); chk("r1_addr2", bus.addr, 6);
        chk("r1_close_ready", bus.in_ready, 0); chk("r1_close_fini", bus.row_fini, 0);
        step(1, 3, 0); #2 chk("r1_fini", bus.row_fini, 1); chk("r1_fini_pop", bus.pop_num, 0);
        chk("r1_fini_take", bus.in_taken, 0);
        step(1, 3, 0); #2 chk("r1_done", bus.row_done, 1); chk("r1_wait_ready", bus.in_ready, 0);
        step(1, 3, 0);
        // drain_ack with in_valid: nothing accepted this cycle
        step(1, 7, 1); #2 chk("drain_take", bus.in_taken, 0); chk("drain_ready", bus.in_ready, 0);

        // Row 2: 7,7 -> clamped 5 then 3
        step(1, 7, 0); #2 chk("r2_ready", bus.in_ready, 1); chk("r2_done_clr", bus.row_done, 0);
        chk("r2_addr_clr", bus.addr, 0); chk("r2_take0", bus.in_taken, 5);
        step(1, 7, 0); #2 chk("r2_pop0", bus.pop_num, 5); chk("r2_addr0", bus.addr, 0);
        chk("r2_take1", bus.in_taken, 3);
        step(0, 0, 0); #2 chk("r2_pop1", bus.pop_num, 3); chk("r2_addr1", bus.addr, 5);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);

        // Row 3: drain_ack in FILL ignored, zero-count beat, 6 clamped to room
        step(1, 4, 0); #2 chk("r3_take0", bus.in_taken, 4);
        step(0, 0, 1); #2 chk("r3_pop0", bus.pop_num, 4); chk("r3_ready", bus.in_ready, 1);
        step(1, 0, 0); #2 chk("r3_zero_take", bus.in_taken, 0); chk("r3_hold_addr", bus.addr, 0);
        step(1, 1, 0); #2 chk("r3_take1", bus.in_taken, 1);
        step(1, 6, 0); #2 chk("r3_pop1", bus.pop_num, 1); chk("r3_addr1", bus.addr, 4);
        chk("r3_take2", bus.in_taken, 3);
        step(0, 0, 0); #2 chk("r3_addr2", bus.addr, 5);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
`ifdef ROW_BUF_CTRL_STATS_EN
        #2 chk("rowcnt_3", bus.row_cnt, 3);
`else
        #2 chk("rowcnt_off", bus.row_cnt, 0);
`endif
        step(0, 0, 1); step(0, 0, 0);

        // Partial row aborted by a mid-cycle reset
        step(1, 5, 0); #2 chk("ab_take", bus.in_taken, 5);
        step(0, 0, 0); #2 chk("ab_pop", bus.pop_num, 5);
        rst = 1'b1;
        #1 chk("ab_rst_pop", bus.pop_num, 0); chk("ab_rst_ready", bus.in_ready, 0);
        chk("ab_rst_cnt", bus.row_cnt, 0);
        step(0, 0, 0); step(0, 0, 0);
        rst = 1'b0;
        step(1, 2, 0); #2 chk("r4_take0", bus.in_taken, 2);
        step(1, 6, 0); #2 chk("r4_pop0", bus.pop_num, 2); chk("r4_addr0", bus.addr, 0);
        chk("r4_take1", bus.in_taken, 5);
        step(1, 1, 0); #2 chk("r4_addr1", bus.addr, 2); chk("r4_take2", bus.in_taken, 1);
        step(0, 0, 0); #2 chk("r4_addr2", bus.addr, 7);
        step(0, 0, 0); #2 chk("r4_fini", bus.row_fini, 1);
        step(0, 0, 0); step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
